wrapper_keys_debounce: RTL and testbench
========================================

// Module: wrapper_keys_debounce
// PURPOSE
//  Conditions the raw board push-buttons before they reach a game core's keys input.
//  Per key: 2-flop synchroniser, debounce FSM, registered level, press/release/auto-repeat strobes.
//  Runs on the same divided clock as the game core, so every strobe is exactly one core cycle.
// PARAMETERS
//  KEYS         4      number of independent keys
//  ACTIVE_LOW   1      1: raw key pin reads 0 when pressed; 0: reads 1 when pressed
//  DB_CYCLES    50000  stable cycles required to accept a change (>=2)
//  REP_DELAY    500000 cycles from press strobe to first repeat strobe (>=2)
//  REP_PERIOD   100000 cycles between later repeat strobes (>=1, <=REP_DELAY)
// PORTS
//  clk           in   1     core clock (divided board clock)
//  reset         in   1     asynchronous, active-low reset
//  keys_in       in   KEYS  raw, asynchronous key pins
//  keys_level    out  KEYS  debounced state, 1 = pressed
//  keys_press    out  KEYS  1-cycle strobe on accepted press
//  keys_release  out  KEYS  1-cycle strobe on accepted release
//  keys_repeat   out  KEYS  1-cycle strobe while held: after REP_DELAY, then every REP_PERIOD
// BEHAVIOUR
//  Reset (reset=0, async):
//   - all outputs 0; all counters 0; every key FSM in IDLE
//   - synchroniser flops load the "released" value (1 if ACTIVE_LOW, else 0)
//   - on release of reset, no strobe fires
//  Input path:
//   - p = sync2 XOR ACTIVE_LOW (1 = pressed)
//   - keys are fully independent; all outputs registered
//  Per-key FSM, db_cnt width $clog2(DB_CYCLES):
//   IDLE      p=1 -> DEB_PRS, db_cnt=0
//   DEB_PRS   p=0 -> IDLE (glitch dropped, no strobe)
//             else db_cnt++
//             at db_cnt==DB_CYCLES-1 -> HELD; level<=1, press<=1, rep_cnt=0
//   HELD      p=0 -> DEB_REL, db_cnt=0; rep_cnt frozen
//             else rep_cnt++
//             first: rep_cnt==REP_DELAY-1 -> repeat<=1, rep_cnt=REP_DELAY-REP_PERIOD
//             result: repeats every REP_PERIOD cycles after the first
//   DEB_REL   p=1 -> HELD (bounce ignored); rep_cnt resumes from frozen value
//             else db_cnt++
//             at db_cnt==DB_CYCLES-1 -> IDLE; level<=0, release<=1
//  Latency:
//   - raw edge to press/release strobe = DB_CYCLES+3 clocks, with a bounce-free input
//   - strobes high exactly one cycle
//   - press and repeat never assert in the same cycle
//  Boundaries:
//   - rep_cnt saturates logic-free: reload keeps it < REP_DELAY, so no wrap
//   - REP_PERIOD==REP_DELAY is legal (uniform repeat)
//   - bounce shorter than DB_CYCLES in either debounce state produces no strobe and no level change
//   - reset mid-debounce or mid-hold: immediate return to IDLE, level 0, no release strobe
// TESTING (bench params: KEYS=4 ACTIVE_LOW=1 DB_CYCLES=4 REP_DELAY=10 REP_PERIOD=3)
//  1. Reset, then keys_in=4'hF for 20 cycles
//     -> all outputs 0; no strobes after reset deassert
//  2. keys_in[0] 1->0 at cycle 0, held
//     -> keys_press[0]=1 only in cycle 7; keys_level[0]=1 from cycle 7
//  3. keys_in[1] low for 3 cycles, then high
//     -> no press strobe; keys_level[1] stays 0
//  4. Continue test 2, hold 30 cycles
//     -> keys_repeat[0] at cycles 17, 20, 23, 26, 29, 32, 35 only
//  5. Release key 0 with 2-cycle bounce, then stable high
//     -> single keys_release[0] 7 cycles after last bounce; level 0; repeat stops
//  6. Keys 2,3 pressed 1 cycle apart; reset=0 pulsed while held
//     -> independent press strobes 1 cycle apart; after reset: all 0, no release strobe

Source files
------------

// File: rtl/wrapper_keys_debounce.sv
// Push-button conditioner: per-key 2-flop synchroniser, debounce FSM, debounced
// level and single-cycle press/release/auto-repeat strobes in the core clock domain.
module wrapper_keys_debounce #(
    parameter int KEYS       = 4,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DB_CYCLES  = 50000,
    parameter int REP_DELAY  = 500000,
    parameter int REP_PERIOD = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [KEYS-1:0] keys_in,
    output logic [KEYS-1:0] keys_level,
    output logic [KEYS-1:0] keys_press,
    output logic [KEYS-1:0] keys_release,
    output logic [KEYS-1:0] keys_repeat
);

    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int REP_W = (REP_DELAY > 1) ? $clog2(REP_DELAY) : 1;

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_PERIOD);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
    localparam logic [KEYS-1:0]  RELEASED   = ACTIVE_LOW ? {KEYS{1'b1}} : {KEYS{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DEB_PRS = 2'd1,
        HELD    = 2'd2,
        DEB_REL = 2'd3
    } state_t;

    // Stage p0/p1: synchroniser, preset to the released pin level so reset exit is quiet
    logic [KEYS-1:0] r_sync_p0;
    logic [KEYS-1:0] r_sync_p1;
    logic [KEYS-1:0] w_pressed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_p0 <= RELEASED;
            r_sync_p1 <= RELEASED;
        end else begin
            r_sync_p0 <= keys_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_pressed = r_sync_p1 ^ {KEYS{ACTIVE_LOW}};

    // Stage p2: independent debounce/repeat FSM per key
    for (genvar k = 0; k < KEYS; k++) begin : g_key
        state_t           r_state;
        state_t           w_state_nx;
        logic [DB_W-1:0]  r_db_cnt;
        logic [DB_W-1:0]  w_db_cnt_nx;
        logic [REP_W-1:0] r_rep_cnt;
        logic [REP_W-1:0] w_rep_cnt_nx;
        logic             r_level;
        logic             w_level_nx;
        logic             r_press;
        logic             w_press_nx;
        logic             r_release;
        logic             w_release_nx;
        logic             r_repeat;
        logic             w_repeat_nx;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state   <= IDLE;
                r_db_cnt  <= '0;
                r_rep_cnt <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_repeat  <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_db_cnt  <= w_db_cnt_nx;
                r_rep_cnt <= w_rep_cnt_nx;
                r_level   <= w_level_nx;
                r_press   <= w_press_nx;
                r_release <= w_release_nx;
                r_repeat  <= w_repeat_nx;
            end
        end

        always_comb begin
            w_state_nx   = r_state;
            w_db_cnt_nx  = r_db_cnt;
            w_rep_cnt_nx = r_rep_cnt;
            w_level_nx   = r_level;
            w_press_nx   = 1'b0;
            w_release_nx = 1'b0;
            w_repeat_nx  = 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_pressed[k]) begin
                        w_state_nx  = DEB_PRS;
                        w_db_cnt_nx = '0;
                    end
                end
                DEB_PRS: begin
                    if (!w_pressed[k]) begin
                        w_state_nx = IDLE;
                    end else if (r_db_cnt == DB_LAST) begin
                        w_state_nx   = HELD;
                        w_level_nx   = 1'b1;
                        w_press_nx   = 1'b1;
                        w_rep_cnt_nx = '0;
                    end else begin
                        w_db_cnt_nx = r_db_cnt + DB_ONE;
                    end
                end
                HELD: begin
                    // A release candidate wins over a due repeat; rep_cnt freezes meanwhile
                    if (!w_pressed[k]) begin
                        w_state_nx  = DEB_REL;
                        w_db_cnt_nx = '0;
                    end else if (r_rep_cnt == REP_LAST) begin
                        w_repeat_nx  = 1'b1;
                        w_rep_cnt_nx = REP_RELOAD;
                    end else begin
                        w_rep_cnt_nx = r_rep_cnt + REP_ONE;
                    end
                end
                DEB_REL: begin
                    if (w_pressed[k]) begin
                        w_state_nx = HELD;
                    end else if (r_db_cnt == DB_LAST) begin
                        w_state_nx   = IDLE;
                        w_level_nx   = 1'b0;
                        w_release_nx = 1'b1;
                    end else begin
                        w_db_cnt_nx = r_db_cnt + DB_ONE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end

        assign keys_level[k]   = r_level;
        assign keys_press[k]   = r_press;
        assign keys_release[k] = r_release;
        assign keys_repeat[k]  = r_repeat;
    end

endmodule

// File: tb/tb_wrapper_keys_debounce.sv
// Scoreboard bench for wrapper_keys_debounce with short debounce/repeat timing.
module tb_wrapper_keys_debounce;

    localparam int KEYS = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [KEYS-1:0] keys_in;
    logic [KEYS-1:0] keys_level;
    logic [KEYS-1:0] keys_press;
    logic [KEYS-1:0] keys_release;
    logic [KEYS-1:0] keys_repeat;

    wrapper_keys_debounce #(
        .KEYS      (KEYS),
        .ACTIVE_LOW(1'b1),
        .DB_CYCLES (4),
        .REP_DELAY (10),
        .REP_PERIOD(3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .keys_in     (keys_in),
        .keys_level  (keys_level),
        .keys_press  (keys_press),
        .keys_release(keys_release),
        .keys_repeat (keys_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_REPEAT  = 2;

    typedef struct {
        int at;
        int kind;
        int key;
    } ev_t;

    ev_t             sb_q[$];
    logic [KEYS-1:0] exp_level = '0;
    logic [KEYS-1:0] exp_p;
    logic [KEYS-1:0] exp_r;
    logic [KEYS-1:0] exp_t;
    bit              mon_en = 1'b0;
    int              n_checks = 0;
    int              n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    endtask

    task automatic push(input int kind, input int key, input int at);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.key  = key;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_p = '0;
            exp_r = '0;
            exp_t = '0;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].at == cyc) begin
                    case (sb_q[i].kind)
                        EV_PRESS:   exp_p[sb_q[i].key] = 1'b1;
                        EV_RELEASE: exp_r[sb_q[i].key] = 1'b1;
                        default:    exp_t[sb_q[i].key] = 1'b1;
                    endcase
                    sb_q.delete(i);
                end
            end
            exp_level = (exp_level | exp_p) & ~exp_r;
            chk("press",   32'(keys_press),   32'(exp_p));
            chk("release", 32'(keys_release), 32'(exp_r));
            chk("repeat",  32'(keys_repeat),  32'(exp_t));
            chk("level",   32'(keys_level),   32'(exp_level));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;

        // Reset with keys released, then quiet run after reset exit
        reset   = 1'b0;
        keys_in = 4'hF;
        tick(3);
        mon_en = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(20);

        // Key 0 press, glitch on key 1, hold with repeats, bouncy release
        t0 = cyc;
        keys_in[0] = 1'b0;
        push(EV_PRESS, 0, t0 + 7);
        for (int k = 0; k < 7; k++) push(EV_REPEAT, 0, t0 + 17 + 3 * k);
        tick(2);
        keys_in[1] = 1'b0;
        tick(3);
        keys_in[1] = 1'b1;
        tick(30);
        keys_in[0] = 1'b1;
        tick(1);
        keys_in[0] = 1'b0;
        tick(1);
        keys_in[0] = 1'b1;
        push(EV_RELEASE, 0, cyc + 7);
        tick(15);

        // Keys 2 and 3 one cycle apart, reset while held, re-press, release
        t1 = cyc;
        keys_in[2] = 1'b0;
        push(EV_PRESS, 2, t1 + 7);
        tick(1);
        keys_in[3] = 1'b0;
        push(EV_PRESS, 3, t1 + 8);
        tick(11);
        reset = 1'b0;
        sb_q.delete();
        exp_level = '0;
        tick(2);
        reset = 1'b1;
        push(EV_PRESS, 2, cyc + 7);
        push(EV_PRESS, 3, cyc + 7);
        tick(11);
        keys_in[3:2] = 2'b11;
        push(EV_RELEASE, 2, cyc + 7);
        push(EV_RELEASE, 3, cyc + 7);
        tick(15);

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
